// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with the central pipeline controller.
// The pipeline (master) reports busy/hazard/MEM-stage status; the controller (slave) returns stall/flush/redirect.
interface pipe_ctrl_if #(
    parameter int IRQ_W = 8
);
    // Handshake: if_busy/mem_busy are "not ready" indications; while either is high every stage
    // holds and nothing in the controller advances, so MEM-stage events are only consumed on
    // cycles where both are low.
    logic             if_busy;
    logic             mem_busy;
    logic             ld_hazard;
    logic             mem_en;
    logic [29:0]      mem_pc;
    logic             mem_br_flag;
    logic [2:0]       mem_exp_code;
    logic             mem_eret;
    logic             creg_we;
    logic [1:0]       creg_addr;
    logic [31:0]      creg_wdata;
    logic [31:0]      creg_rd_data;
    logic [IRQ_W-1:0] irq;
    logic             if_stall;
    logic             id_stall;
    logic             ex_stall;
    logic             mem_stall;
    logic             if_flush;
    logic             id_flush;
    logic             ex_flush;
    logic             mem_flush;
    logic [29:0]      new_pc;
    logic             int_detect;
    logic             drain_state;

    modport master (
        output if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_br_flag, mem_exp_code,
               mem_eret, creg_we, creg_addr, creg_wdata, irq,
        input  creg_rd_data, if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, new_pc, int_detect, drain_state
    );

    modport slave (
        input  if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_br_flag, mem_exp_code,
               mem_eret, creg_we, creg_addr, creg_wdata, irq,
        output creg_rd_data, if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, new_pc, int_detect, drain_state
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline; takes exceptions and erets at MEM
// and owns the STATUS / INT_MASK / EPC / EXP_CODE control registers.
module pipe_ctrl #(
    parameter logic [29:0] EXC_VECTOR = 30'h0000_0000,
    parameter int          IRQ_W      = 8
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             int_en;
    logic             pie;
    logic [IRQ_W-1:0] int_mask;
    logic [29:0]      epc;
    logic [2:0]       exp_code_q;
    logic             int_detect_q;

    logic             stall_all;
    logic             exc_take;
    logic             eret_take;
    logic             flush_now;
    logic             irq_pending;

    assign stall_all   = bus.if_busy | bus.mem_busy;
    assign exc_take    = !stall_all && bus.mem_en && (bus.mem_exp_code != 3'd0) && (state == RUN);
    assign eret_take   = !stall_all && bus.mem_en && bus.mem_eret &&
                         (bus.mem_exp_code == 3'd0) && (state == RUN);
    assign flush_now   = exc_take | eret_take;
    assign irq_pending = |(bus.irq & ~int_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus all stall/flush/redirect outputs; outputs read 0 while reset is held.
    always_comb begin
        state_next    = state;
        bus.if_stall  = 1'b0;
        bus.id_stall  = 1'b0;
        bus.ex_stall  = 1'b0;
        bus.mem_stall = 1'b0;
        bus.if_flush  = 1'b0;
        bus.id_flush  = 1'b0;
        bus.ex_flush  = 1'b0;
        bus.mem_flush = 1'b0;
        bus.new_pc    = 30'd0;
        if (!stall_all) begin
            if (state == DRAIN) begin
                state_next = RUN;
            end else if (flush_now) begin
                state_next = DRAIN;
            end
        end
        if (!reset) begin
            if (stall_all) begin
                bus.if_stall  = 1'b1;
                bus.id_stall  = 1'b1;
                bus.ex_stall  = 1'b1;
                bus.mem_stall = 1'b1;
            end else if (flush_now) begin
                bus.if_flush  = 1'b1;
                bus.id_flush  = 1'b1;
                bus.ex_flush  = 1'b1;
                bus.mem_flush = 1'b1;
                bus.new_pc    = exc_take ? EXC_VECTOR : epc;
            end else if (bus.ld_hazard) begin
                bus.if_stall = 1'b1;
                bus.id_stall = 1'b1;
                bus.id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int_en       <= 1'b0;
            pie          <= 1'b0;
            int_mask     <= '1;
            epc          <= 30'd0;
            exp_code_q   <= 3'd0;
            int_detect_q <= 1'b0;
        end else if (!stall_all) begin
            int_detect_q <= (state == RUN) && int_en && irq_pending && !flush_now;
            // A register write racing an exception entry is dropped; eret below overrides int_en.
            if (bus.creg_we && !exc_take) begin
                case (bus.creg_addr)
                    2'd0: begin
                        int_en <= bus.creg_wdata[0];
                        pie    <= bus.creg_wdata[1];
                    end
                    2'd1:    int_mask <= bus.creg_wdata[IRQ_W-1:0];
                    2'd2:    epc      <= bus.creg_wdata[29:0];
                    default: ;
                endcase
            end
            if (exc_take) begin
                epc        <= bus.mem_br_flag ? (bus.mem_pc - 30'd1) : bus.mem_pc;
                exp_code_q <= bus.mem_exp_code;
                pie        <= int_en;
                int_en     <= 1'b0;
            end else if (eret_take) begin
                int_en <= pie;
            end
        end
    end

    always_comb begin
        bus.creg_rd_data = 32'd0;
        case (bus.creg_addr)
            2'd0:    bus.creg_rd_data[1:0]       = {pie, int_en};
            2'd1:    bus.creg_rd_data[IRQ_W-1:0] = int_mask;
            2'd2:    bus.creg_rd_data[29:0]      = epc;
            default: bus.creg_rd_data[2:0]       = exp_code_q;
        endcase
    end

    assign bus.int_detect  = int_detect_q;
    assign bus.drain_state = (state == DRAIN);

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage CPU.
- Generates the stall/flush/int_detect controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Takes exceptions and interrupts at the MEM stage, redirects the PC, and owns the exception control registers (STATUS, INT_MASK, EPC, EXP_CODE).
- Sits beside the pipeline registers; drives new_pc into the fetch stage.

Parameters:
EXC_VECTOR, 30'h0000_0000, word address loaded on exception entry
IRQ_W, 8, number of external interrupt lines

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_busy  in  1  fetch bus access pending
mem_busy  in  1  data bus access pending
ld_hazard  in  1  load-use hazard detected in ID
mem_en  in  1  MEM-stage instruction valid
mem_pc  in  30  MEM-stage word PC
mem_br_flag  in  1  MEM-stage instruction sits in a branch delay slot
mem_exp_code  in  3  MEM-stage exception code, 0 = none, 1 = external interrupt
mem_eret  in  1  MEM-stage return-from-exception
creg_we  in  1  control-register write from MEM stage
creg_addr  in  2  write/read register index
creg_wdata  in  32  write data
creg_rd_data  out  32  combinational read of creg_addr
irq  in  IRQ_W  level-sensitive interrupt requests
if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the stage register
if_flush, id_flush, ex_flush, mem_flush  out  1 each  clear the stage register
new_pc  out  30  redirect target, valid while if_flush=1
int_detect  out  1  tag the ID/EX instruction as interrupted

Behaviour:
- Reset, synchronous on clk:
  - Registers: state=RUN, int_en=0, pie=0, int_mask=all 1s, epc=0, exp_code_q=0, int_detect=0.
  - All stall/flush outputs are combinational and read 0 during reset; new_pc=0.
- Control registers:
  - 0 STATUS: bit0 int_en, bit1 pie.
  - 1 INT_MASK: bits IRQ_W-1:0, 1 = masked.
  - 2 EPC: bits 29:0.
  - 3 EXP_CODE: bits 2:0, read-only; writes ignored.
  - Unused bits read 0. Writes take effect at the clock edge when creg_we=1 and stall_all=0.
- stall_all = if_busy | mem_busy. While stall_all=1:
  - All four stalls = 1, all flushes = 0.
  - No state, register or int_detect update occurs; exceptions and eret are deferred until the stall clears.
- Exception take (stall_all=0, mem_en=1, mem_exp_code!=0, state=RUN):
  - Same cycle: all four flushes = 1, new_pc = EXC_VECTOR; ld_hazard is ignored.
  - At the edge: epc = mem_br_flag ? mem_pc-1 : mem_pc (modulo 2^30); exp_code_q = mem_exp_code; pie = int_en; int_en = 0; state -> DRAIN.
  - A concurrent creg_we is dropped.
- Eret (stall_all=0, mem_en=1, mem_eret=1, no exception, state=RUN):
  - Same cycle: all flushes = 1, new_pc = epc.
  - At the edge: int_en = pie; state -> DRAIN.
- Exception has priority over eret.
- Load-use (stall_all=0, no exception/eret, ld_hazard=1):
  - if_stall = id_stall = 1, id_flush = 1 (bubble into ID/EX).
  - ex_stall = mem_stall = 0; all other flushes = 0.
- DRAIN:
  - Lasts exactly one cycle, then returns to RUN.
  - Exceptions/eret seen in DRAIN are ignored (pipeline already flushed).
  - int_detect is forced 0.
  - If stall_all=1, DRAIN holds.
- int_detect:
  - Registered: next = (state==RUN) & int_en & |(irq & ~int_mask) & ~flush_now.
  - Updates only when stall_all=0. It stays asserted while the request is pending.
  - Cleared the cycle after an exception take, because int_en drops.
- Default (nothing pending): all stalls and flushes 0, new_pc = 0.

Test Plan:
- Reset, then read regs 0..3 → 0, 8'hFF, 0, 0; all stall/flush outputs 0; int_detect=0.
- ld_hazard=1 with no busy → if_stall=id_stall=id_flush=1, ex_stall=mem_stall=0; when if_busy=1 is added → all stalls 1, id_flush=0.
- Write STATUS=1, INT_MASK=8'hFE; irq=8'h01 → int_detect=1 one cycle later. Then drive mem_exp_code=1, mem_pc=30'h100, mem_br_flag=1 → all flushes=1 and new_pc=EXC_VECTOR that cycle. Afterwards EPC=30'h0FF, EXP_CODE=1, STATUS=2'b10, int_detect=0.
- mem_eret=1 after the prior exception → flushes=1, new_pc=30'h0FF, then STATUS bit0=1. A second eret in the following (DRAIN) cycle → no flush.
- mem_exp_code=3 together with mem_busy=1 for 3 cycles → no flush and EPC unchanged during the stall; flush occurs on the first cycle with mem_busy=0.
- Exception and eret together, with creg_we to EPC in the same cycle → exception wins, new_pc=EXC_VECTOR, EPC=mem_pc (the write is dropped).
